// File: rtl/cur_blk_addr_gen.sv
// cur_blk_addr_gen: current-frame byte address generator for motion estimation.
// Walks the frame in raster block order, and in raster pixel order inside each
// block. It issues one address per accepted cycle and stalls while pause_in is high.
// Optional feature macro: CUR_BLK_ADDR_SUBSAMPLE_EN. When it is defined, rows
// inside a block step by two.
`timescale 1ns/1ps

module cur_blk_addr_gen #(
  parameter int     FRAME_W       = 1920,
  parameter int     FRAME_H       = 1088,
  parameter int     BLK_W         = 32,
  parameter int     BLK_H         = 32,
  parameter int     BYTES_PER_PIX = 2,
  parameter longint BASE_ADDR     = 0,
  parameter int     ADDR_W        = 23,
  parameter int     CONTINUOUS    = 0,
  localparam int    NBX           = FRAME_W / BLK_W,
  localparam int    NBY           = FRAME_H / BLK_H,
  localparam int    BX_W          = (NBX > 1) ? $clog2(NBX) : 1,
  localparam int    BY_W          = (NBY > 1) ? $clog2(NBY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause_in,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [BX_W-1:0]   blk_x,
  output logic [BY_W-1:0]   blk_y,
  output logic              blk_first,
  output logic              blk_last,
  output logic              frame_done,
  output logic              busy,
  output logic              pause_out
);

`ifdef CUR_BLK_ADDR_SUBSAMPLE_EN
  localparam int ROW_STEP = 2;
`else
  localparam int ROW_STEP = 1;
`endif

  localparam int COL_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  // Address deltas. They are truncated to ADDR_W, so modulo-2^ADDR_W wrap comes for free.
  localparam logic [ADDR_W-1:0] ORIGIN    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PIX_STEP  = ADDR_W'(longint'(BYTES_PER_PIX));
  // Moves from the last column of one block row-line to column 0 of the next sampled line.
  localparam logic [ADDR_W-1:0] ROW_JUMP  =
    ADDR_W'((longint'(ROW_STEP) * FRAME_W - longint'(BLK_W - 1)) * BYTES_PER_PIX);
  localparam logic [ADDR_W-1:0] BLK_JUMP  = ADDR_W'(longint'(BLK_W) * BYTES_PER_PIX);
  localparam logic [ADDR_W-1:0] BROW_JUMP =
    ADDR_W'(longint'(BLK_H) * FRAME_W * BYTES_PER_PIX);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BLK_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_H - ROW_STEP);
  localparam logic [ROW_W-1:0] ROW_INC  = ROW_W'(ROW_STEP);
  localparam logic [BX_W-1:0]  BX_LAST  = BX_W'(NBX - 1);
  localparam logic [BY_W-1:0]  BY_LAST  = BY_W'(NBY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;   // address of pixel (0,0) of the current block
  logic [ADDR_W-1:0] row_base_q, row_base_d;   // address of pixel (0,0) of the current block row
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BX_W-1:0]   bx_q, bx_d;
  logic [BY_W-1:0]   by_q, by_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic col_end, row_end, bx_end, by_end;

  // Handshake outputs and end-of-range decodes of the current counters
  always_comb begin
    accept  = (state_q == ST_RUN) && !pause_in;
    col_end = (col_q == COL_LAST);
    row_end = (row_q == ROW_LAST);
    bx_end  = (bx_q == BX_LAST);
    by_end  = (by_q == BY_LAST);
  end

  // Next-state and counter/address update; nothing moves unless an address is accepted
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    blk_base_d   = blk_base_q;
    row_base_d   = row_base_q;
    col_d        = col_q;
    row_d        = row_q;
    bx_d         = bx_q;
    by_d         = by_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          addr_d     = ORIGIN;
          blk_base_d = ORIGIN;
          row_base_d = ORIGIN;
          col_d      = '0;
          row_d      = '0;
          bx_d       = '0;
          by_d       = '0;
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (!col_end) begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + PIX_STEP;
          end else if (!row_end) begin
            col_d  = '0;
            row_d  = row_q + ROW_INC;
            addr_d = addr_q + ROW_JUMP;
          end else if (!bx_end) begin
            col_d      = '0;
            row_d      = '0;
            bx_d       = bx_q + BX_W'(1);
            blk_base_d = blk_base_q + BLK_JUMP;
            addr_d     = blk_base_q + BLK_JUMP;
          end else if (!by_end) begin
            col_d      = '0;
            row_d      = '0;
            bx_d       = '0;
            by_d       = by_q + BY_W'(1);
            row_base_d = row_base_q + BROW_JUMP;
            blk_base_d = row_base_q + BROW_JUMP;
            addr_d     = row_base_q + BROW_JUMP;
          end else begin
            // Last address of the frame has been accepted
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
            bx_d         = '0;
            by_d         = '0;
            if (CONTINUOUS != 0) begin
              addr_d     = ORIGIN;
              blk_base_d = ORIGIN;
              row_base_d = ORIGIN;
            end else begin
              state_d    = ST_DONE;
              addr_d     = '0;
              blk_base_d = '0;
              row_base_d = '0;
            end
          end
        end
      end

      ST_DONE: begin
        // start is deliberately not sampled here
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flags follow the counters so they travel with addr and hold while paused
    first_d = (state_d == ST_RUN) && (col_d == '0) && (row_d == '0);
    last_d  = (state_d == ST_RUN) && (col_d == COL_LAST) && (row_d == ROW_LAST);
  end

  // State, counter and output registers; reset aborts any scan in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      blk_base_q   <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      blk_base_q   <= blk_base_d;
      row_base_q   <= row_base_d;
      col_q        <= col_d;
      row_q        <= row_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      first_q      <= first_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = accept;
  assign blk_x      = bx_q;
  assign blk_y      = by_q;
  assign blk_first  = first_q;
  assign blk_last   = last_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign pause_out  = pause_in;

endmodule
